// File: rtl/id_pkg.sv
// Decode-stage constants: opcodes, ALUOp codes, ctrl bit positions and the opcode decoder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package id_pkg;

    localparam int CTRL_W = 11;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp codes handed to the EX-stage ALU controller
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    // Bit positions inside the ctrl word
    localparam int C_REG_WRITE  = 10;
    localparam int C_MEM_TO_REG = 9;   // 1 = write back ALU result, 0 = load data
    localparam int C_MEM_READ   = 8;
    localparam int C_MEM_WRITE  = 7;
    localparam int C_BRANCH     = 6;
    localparam int C_BRANCH_NE  = 5;
    localparam int C_JUMP       = 4;
    localparam int C_ALU_SRC    = 3;
    localparam int C_REG_DST    = 2;
    localparam int C_ALU_OP     = 0;   // two bits, [1:0]

    typedef struct packed {
        logic              illegal;
        logic [CTRL_W-1:0] ctrl;
    } dec_t;

    // All-zero word is the canonical nop and must not look like an R-type ALU op.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.illegal = 1'b0;
        d.ctrl    = '0;
        if (instr != 32'd0) begin
            case (instr[31:26])
                OP_RTYPE: begin
                    d.ctrl[C_REG_WRITE]     = 1'b1;
                    d.ctrl[C_MEM_TO_REG]    = 1'b1;
                    d.ctrl[C_REG_DST]       = 1'b1;
                    d.ctrl[C_ALU_OP +: 2]   = ALU_FUNCT;
                end
                OP_ADDI: begin
                    d.ctrl[C_REG_WRITE]     = 1'b1;
                    d.ctrl[C_MEM_TO_REG]    = 1'b1;
                    d.ctrl[C_ALU_SRC]       = 1'b1;
                    d.ctrl[C_ALU_OP +: 2]   = ALU_ADD;
                end
                OP_ANDI: begin
                    d.ctrl[C_REG_WRITE]     = 1'b1;
                    d.ctrl[C_MEM_TO_REG]    = 1'b1;
                    d.ctrl[C_ALU_SRC]       = 1'b1;
                    d.ctrl[C_ALU_OP +: 2]   = ALU_AND;
                end
                OP_LW: begin
                    d.ctrl[C_REG_WRITE]     = 1'b1;
                    d.ctrl[C_MEM_READ]      = 1'b1;
                    d.ctrl[C_ALU_SRC]       = 1'b1;
                    d.ctrl[C_ALU_OP +: 2]   = ALU_ADD;
                end
                OP_SW: begin
                    d.ctrl[C_MEM_WRITE]     = 1'b1;
                    d.ctrl[C_ALU_SRC]       = 1'b1;
                    d.ctrl[C_ALU_OP +: 2]   = ALU_ADD;
                end
                OP_BEQ: begin
                    d.ctrl[C_BRANCH]        = 1'b1;
                    d.ctrl[C_ALU_OP +: 2]   = ALU_SUB;
                end
                OP_BNE: begin
                    d.ctrl[C_BRANCH]        = 1'b1;
                    d.ctrl[C_BRANCH_NE]     = 1'b1;
                    d.ctrl[C_ALU_OP +: 2]   = ALU_SUB;
                end
                OP_J: begin
                    d.ctrl[C_JUMP]          = 1'b1;
                end
                default: begin
                    d.illegal = 1'b1;
                end
            endcase
        end
        return d;
    endfunction

    // Opcodes that read rt as a source operand (rt is a destination for I-type ALU/loads).
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: two async read ports with write-back bypass, one sync write port, sync clear.
// Latency: reads combinational; write visible in storage after the clock edge, via bypass same cycle.
// Backpressure: none; writes are always accepted (or dropped if the address is not writable).
// Ports: clock_i/reset_i; raddr1_i/raddr2_i -> rdata1_o/rdata2_o; wen_i/waddr_i/wdata_i write port.
module id_regfile
    import id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            wen_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] mem_q [NREG];
    logic            wr_ok;

    // An address is "live" if it exists and is not the hard-wired zero register.
    // The same test gates writes, bypass and reads, so a dropped write can never be bypassed.
    function automatic logic addr_ok(input logic [4:0] a);
        return (32'(a) < NREG) && !(ZERO_REG && (a == 5'd0));
    endfunction

    assign wr_ok = wen_i && addr_ok(waddr_i);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (addr_ok(raddr1_i)) begin
            rdata1_o = (wr_ok && (raddr1_i == waddr_i)) ? wdata_i : mem_q[raddr1_i[AW-1:0]];
        end
        if (addr_ok(raddr2_i)) begin
            rdata2_o = (wr_ok && (raddr2_i == waddr_i)) ? wdata_i : mem_q[raddr2_i[AW-1:0]];
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: register read, control decode, sign-extend, jump target, load-use hazard detect.
// Latency: 1 cycle IF/ID -> ID/EX register; stall output is combinational in the same cycle.
// Backpressure: raises stall on a load-use hazard and injects a bubble; flush overrides stall.
// Ports: clock/reset; IF/ID in (if_valid, pc_in, instr); flush; EX load info (ex_mem_read, ex_rt);
//        WB write port (wb_en, wb_addr, wb_data); out: stall, ID/EX fields (id_valid, ctrl, illegal,
//        pc_out, rdata1/2, imm, rs/rt/rd, j_target).
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [31:0]       instr,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall,
    output logic              id_valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    output logic [XLEN-1:0]   imm,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [XLEN-1:0]   j_target
);

    logic [5:0]      opcode;
    logic [4:0]      f_rs, f_rt, f_rd;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    dec_t            dec;
    logic            bubble;

    logic              id_valid_d, id_valid_q;
    logic [CTRL_W-1:0] ctrl_d,     ctrl_q;
    logic              illegal_d,  illegal_q;
    logic [XLEN-1:0]   imm_d,      imm_q;
    logic [XLEN-1:0]   jt_d,       jt_q;
    logic [XLEN-1:0]   pc_q, rdata1_q, rdata2_q;
    logic [4:0]        rs_q, rt_q, rd_q;

    assign opcode = instr[31:26];
    assign f_rs   = instr[25:21];
    assign f_rt   = instr[20:16];
    assign f_rd   = instr[15:11];

    id_regfile #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clock_i  (clock),
        .reset_i  (reset),
        .raddr1_i (f_rs),
        .raddr2_i (f_rt),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2),
        .wen_i    (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    // Load-use hazard: the load in EX cannot forward in time, so hold one cycle.
    // A flushed instruction is discarded anyway, so it never stalls.
    always_comb begin
        stall = if_valid && !flush && ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == f_rs) || ((ex_rt == f_rt) && uses_rt(opcode)));
    end

    always_comb begin
        dec        = decode(instr);
        bubble     = !if_valid || flush || stall;
        id_valid_d = !bubble;
        ctrl_d     = bubble ? '0 : dec.ctrl;
        illegal_d  = bubble ? 1'b0 : dec.illegal;
        imm_d      = {{(XLEN-16){instr[15]}}, instr[15:0]};
        jt_d       = {pc_in[XLEN-1:28], instr[25:0], 2'b00};
    end

    // Data fields load every cycle; only the control side is squashed on a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
            pc_q       <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            jt_q       <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
            pc_q       <= pc_in;
            rdata1_q   <= rf_rdata1;
            rdata2_q   <= rf_rdata2;
            imm_q      <= imm_d;
            rs_q       <= f_rs;
            rt_q       <= f_rt;
            rd_q       <= f_rd;
            jt_q       <= jt_d;
        end
    end

    assign id_valid = id_valid_q;
    assign ctrl     = ctrl_q;
    assign illegal  = illegal_q;
    assign pc_out   = pc_q;
    assign rdata1   = rdata1_q;
    assign rdata2   = rdata2_q;
    assign imm      = imm_q;
    assign rs       = rs_q;
    assign rt       = rt_q;
    assign rd       = rd_q;
    assign j_target = jt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: 32-bit default instance plus a 64-bit / 16-register instance.
// Latency: outputs checked 1 ns after the capturing edge; stall checked combinationally.
// Backpressure: exercised through load-use stall and flush scenarios.
module tb_id_stage_pipe;

    logic        clock = 1'b0;
    logic        reset, if_valid, flush, ex_mem_read, wb_en;
    logic [31:0] pc_in, instr, wb_data;
    logic [4:0]  ex_rt, wb_addr;

    logic        stall, id_valid, illegal;
    logic [10:0] ctrl;
    logic [31:0] pc_out, rdata1, rdata2, imm, j_target;
    logic [4:0]  rs, rt, rd;

    logic [63:0] pc_in64, wb_data64;
    logic        stall64, id_valid64, illegal64;
    logic [10:0] ctrl64;
    logic [63:0] pc_out64, rdata1_64, rdata2_64, imm64, j_target64;
    logic [4:0]  rs64, rt64, rd64;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    id_stage_pipe dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .pc_in(pc_in), .instr(instr),
        .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .id_valid(id_valid),
        .ctrl(ctrl), .illegal(illegal), .pc_out(pc_out), .rdata1(rdata1), .rdata2(rdata2),
        .imm(imm), .rs(rs), .rt(rt), .rd(rd), .j_target(j_target)
    );

    id_stage_pipe #(.XLEN(64), .NREG(16), .ZERO_REG(1'b1)) dut64 (
        .clock(clock), .reset(reset), .if_valid(if_valid), .pc_in(pc_in64), .instr(instr),
        .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data64), .stall(stall64), .id_valid(id_valid64),
        .ctrl(ctrl64), .illegal(illegal64), .pc_out(pc_out64), .rdata1(rdata1_64),
        .rdata2(rdata2_64), .imm(imm64), .rs(rs64), .rt(rt64), .rd(rd64), .j_target(j_target64)
    );

    function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] d);
        return {6'b000000, s, t, d, 5'b00000, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        if_valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_data64 = 64'd0;
        instr = 32'd0; pc_in = 32'd0; pc_in64 = 64'd0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1; if_valid = 1'b1; pc_in = 32'h100; instr = r_type(5'd1, 5'd2, 5'd3);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD;   // write must be dropped
        tick(); tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got %h exp 0", id_valid); end
        checks++; if (ctrl !== 11'h000) begin failures++; $display("FAIL reset_ctrl got %h exp 000", ctrl); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got %h exp 0", illegal); end
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out got %h exp 0", pc_out); end
        checks++; if (imm !== 32'h0) begin failures++; $display("FAIL reset_imm got %h exp 0", imm); end
        reset = 1'b0; wb_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            instr = r_type(5'(i), 5'(i), 5'd0);
            tick();
            checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_rf_rs r%0d got %h exp 0", i, rdata1); end
            checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL reset_rf_rt r%0d got %h exp 0", i, rdata2); end
        end
        checks++; if (ctrl !== 11'h606) begin failures++; $display("FAIL rtype_ctrl got %h exp 606", ctrl); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL rtype_valid got %h exp 1", id_valid); end
    endtask

    task automatic test_bypass;
        idle_inputs(); if_valid = 1'b1;
        instr = r_type(5'd8, 5'd8, 5'd9);
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
        tick();
        checks++; if (rdata1 !== 32'h1234) begin failures++; $display("FAIL bypass_rs got %h exp 1234", rdata1); end
        checks++; if (rdata2 !== 32'h1234) begin failures++; $display("FAIL bypass_rt got %h exp 1234", rdata2); end
        checks++; if (rd !== 5'd9) begin failures++; $display("FAIL bypass_rd got %0d exp 9", rd); end
        wb_en = 1'b0;
        tick();
        checks++; if (rdata1 !== 32'h1234) begin failures++; $display("FAIL stored_rs got %h exp 1234", rdata1); end
        // one-port bypass: rs sees new data, rt (r9 never written) stays 0
        instr = r_type(5'd8, 5'd9, 5'd1);
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h5555;
        tick();
        checks++; if (rdata1 !== 32'h5555) begin failures++; $display("FAIL bypass1_rs got %h exp 5555", rdata1); end
        checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL bypass1_rt got %h exp 0", rdata2); end
        wb_en = 1'b0;
    endtask

    task automatic test_stall;
        idle_inputs(); if_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8;
        instr = r_type(5'd8, 5'd0, 5'd9); #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_rs got %h exp 1", stall); end
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stall_bubble_valid got %h exp 0", id_valid); end
        checks++; if (ctrl !== 11'h000) begin failures++; $display("FAIL stall_bubble_ctrl got %h exp 000", ctrl); end
        instr = i_type(6'b101011, 5'd10, 5'd8, 16'h0004); #1;   // sw reads rt
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_sw_rt got %h exp 1", stall); end
        instr = i_type(6'b001000, 5'd10, 5'd8, 16'h0005); #1;   // addi rt is a destination
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_addi_rt got %h exp 0", stall); end
        tick();
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got %h exp 1", id_valid); end
        checks++; if (ctrl !== 11'h608) begin failures++; $display("FAIL addi_ctrl got %h exp 608", ctrl); end
        checks++; if (imm !== 32'h5) begin failures++; $display("FAIL addi_imm got %h exp 5", imm); end
        checks++; if (rs !== 5'd10 || rt !== 5'd8) begin failures++; $display("FAIL addi_fields got %0d/%0d exp 10/8", rs, rt); end
        ex_rt = 5'd0; instr = r_type(5'd0, 5'd0, 5'd9); #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_r0 got %h exp 0", stall); end
        ex_rt = 5'd8; ex_mem_read = 1'b0; instr = r_type(5'd8, 5'd0, 5'd9); #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_noload got %h exp 0", stall); end
        ex_mem_read = 1'b1; if_valid = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_novalid got %h exp 0", stall); end
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL novalid_bubble got %h exp 0", id_valid); end
    endtask

    task automatic test_flush;
        idle_inputs(); if_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; flush = 1'b1;
        instr = {6'b111111, 5'd8, 21'd0}; #1;                   // hazard + illegal, both squashed
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got %h exp 0", stall); end
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %h exp 0", id_valid); end
        checks++; if (ctrl !== 11'h000) begin failures++; $display("FAIL flush_ctrl got %h exp 000", ctrl); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL flush_illegal got %h exp 0", illegal); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins  [8];
        logic [10:0] ectl [8];
        logic [31:0] eimm [8];
        ins[0] = r_type(5'd1, 5'd2, 5'd3);                     ectl[0] = 11'h606; eimm[0] = 32'h0000_1820;
        ins[1] = i_type(6'b001000, 5'd1, 5'd4, 16'h8001);      ectl[1] = 11'h608; eimm[1] = 32'hFFFF_8001;
        ins[2] = i_type(6'b001100, 5'd1, 5'd5, 16'h00FF);      ectl[2] = 11'h60B; eimm[2] = 32'h0000_00FF;
        ins[3] = i_type(6'b100011, 5'd6, 5'd5, 16'hFFF8);      ectl[3] = 11'h508; eimm[3] = 32'hFFFF_FFF8;
        ins[4] = i_type(6'b101011, 5'd6, 5'd5, 16'h0010);      ectl[4] = 11'h088; eimm[4] = 32'h0000_0010;
        ins[5] = i_type(6'b000100, 5'd3, 5'd4, 16'h0008);      ectl[5] = 11'h041; eimm[5] = 32'h0000_0008;
        ins[6] = i_type(6'b000101, 5'd1, 5'd2, 16'hFFFC);      ectl[6] = 11'h061; eimm[6] = 32'hFFFF_FFFC;
        ins[7] = 32'd0;                                        ectl[7] = 11'h000; eimm[7] = 32'h0;
        idle_inputs(); if_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            instr = ins[k]; pc_in = 32'h1000 + 32'(4 * k);
            tick();
            checks++; if (ctrl !== ectl[k]) begin failures++; $display("FAIL dec_ctrl[%0d] got %h exp %h", k, ctrl, ectl[k]); end
            checks++; if (imm !== eimm[k]) begin failures++; $display("FAIL dec_imm[%0d] got %h exp %h", k, imm, eimm[k]); end
            checks++; if (id_valid !== 1'b1 || illegal !== 1'b0) begin failures++; $display("FAIL dec_flags[%0d] got v=%h i=%h exp v=1 i=0", k, id_valid, illegal); end
            checks++; if (pc_out !== 32'h1000 + 32'(4 * k)) begin failures++; $display("FAIL dec_pc[%0d] got %h", k, pc_out); end
        end
    endtask

    task automatic test_illegal;
        idle_inputs(); if_valid = 1'b1;
        instr = {6'b111111, 26'd0};
        tick();
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_flag got %h exp 1", illegal); end
        checks++; if (ctrl !== 11'h000) begin failures++; $display("FAIL illegal_ctrl got %h exp 000", ctrl); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL illegal_valid got %h exp 1", id_valid); end
        instr = 32'd0;
        tick();
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_clear got %h exp 0", illegal); end
        checks++; if (id_valid !== 1'b1 || ctrl !== 11'h000) begin failures++; $display("FAIL nop got v=%h c=%h exp v=1 c=000", id_valid, ctrl); end
    endtask

    task automatic test_zero_reg;
        idle_inputs(); if_valid = 1'b1;
        instr = r_type(5'd0, 5'd0, 5'd1);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        tick();
        checks++; if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin failures++; $display("FAIL r0_bypass got %h/%h exp 0/0", rdata1, rdata2); end
        wb_en = 1'b0;
        tick();
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL r0_stored got %h exp 0", rdata1); end
    endtask

    task automatic test_jump;
        idle_inputs(); if_valid = 1'b1;
        pc_in = 32'h4000_0004; instr = {6'b000010, 26'h000_0010};
        tick();
        checks++; if (j_target !== 32'h4000_0040) begin failures++; $display("FAIL j_target got %h exp 40000040", j_target); end
        checks++; if (ctrl !== 11'h010) begin failures++; $display("FAIL j_ctrl got %h exp 010", ctrl); end
        checks++; if (pc_out !== 32'h4000_0004) begin failures++; $display("FAIL j_pc got %h exp 40000004", pc_out); end
    endtask

    task automatic test_param64;
        idle_inputs(); if_valid = 1'b1;
        instr = r_type(5'd15, 5'd16, 5'd1);
        wb_en = 1'b1; wb_addr = 5'd15; wb_data64 = 64'h0123_4567_89AB_CDEF;
        tick();
        checks++; if (rdata1_64 !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL p64_bypass got %h", rdata1_64); end
        checks++; if (rdata2_64 !== 64'h0) begin failures++; $display("FAIL p64_oob_rt got %h exp 0", rdata2_64); end
        instr = r_type(5'd20, 5'd15, 5'd1);
        wb_addr = 5'd20; wb_data64 = 64'hFFFF_FFFF_FFFF_FFFF;   // out of range: dropped, no bypass
        tick();
        checks++; if (rdata1_64 !== 64'h0) begin failures++; $display("FAIL p64_oob_rs got %h exp 0", rdata1_64); end
        checks++; if (rdata2_64 !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL p64_stored got %h", rdata2_64); end
        wb_en = 1'b0;
        pc_in64 = 64'h1234_5678_4000_0004;
        instr = i_type(6'b000101, 5'd1, 5'd2, 16'hFFFC);
        tick();
        checks++; if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL p64_imm got %h", imm64); end
        checks++; if (ctrl64 !== 11'h061) begin failures++; $display("FAIL p64_bne_ctrl got %h exp 061", ctrl64); end
        instr = {6'b000010, 26'h000_0010};
        tick();
        checks++; if (j_target64 !== 64'h1234_5678_4000_0040) begin failures++; $display("FAIL p64_j_target got %h", j_target64); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_bypass();
        test_stall();
        test_flush();
        test_back_to_back();
        test_illegal();
        test_zero_reg();
        test_jump();
        test_param64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
